lab3_mem_line_mem_responder: RTL and testbench

//  Main-memory responder at the memory side of the blocking cache's memreq/memresp val/rdy interface.

---
 rtl/lab3_mem_line_mem_responder.sv | 94 +++++++++
 tb/tb_lab3_mem_line_mem_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lab3_mem_line_mem_responder.sv
// Line-granular backing memory on the memreq/memresp val/rdy interface.
// Handles one outstanding request and answers it after a fixed number of wait cycles.
module lab3_mem_line_mem_responder #(
    parameter int p_num_lines = 16,
    parameter int p_latency   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memreq_val,
    output logic         memreq_rdy,
    input  logic [2:0]   memreq_type,
    input  logic [7:0]   memreq_opaque,
    input  logic [31:0]  memreq_addr,
    input  logic [127:0] memreq_data,
    output logic         memresp_val,
    input  logic         memresp_rdy,
    output logic [2:0]   memresp_type,
    output logic [7:0]   memresp_opaque,
    output logic [127:0] memresp_data
);
    localparam int IW = $clog2(p_num_lines);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state, state_next;
    logic [7:0]     cnt;
    logic [127:0]   storage [p_num_lines];
    logic [IW-1:0]  idx;
    logic           accept;
    logic           is_store;
    logic           unused_addr;

    assign idx         = memreq_addr[4 +: IW];
    assign accept      = (state == IDLE) && memreq_val;
    assign is_store    = (memreq_type == 3'd1) || (memreq_type == 3'd2);
    assign unused_addr = ^{memreq_addr[31:4+IW], memreq_addr[3:0]};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        memreq_rdy  = 1'b0;
        memresp_val = 1'b0;
        case (state)
            IDLE: begin
                memreq_rdy = 1'b1;
                if (memreq_val) state_next = (p_latency == 0) ? RESP : WAIT;
            end
            WAIT: begin
                if (cnt == 8'd1) state_next = RESP;
            end
            RESP: begin
                memresp_val = 1'b1;
                if (memresp_rdy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Stores commit at acceptance, so a following read of the same line sees the new data.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt            <= 8'd0;
            memresp_type   <= 3'd0;
            memresp_opaque <= 8'd0;
            memresp_data   <= 128'd0;
            for (int i = 0; i < p_num_lines; i++) storage[i] <= 128'd0;
        end else if (accept) begin
            cnt            <= 8'(p_latency);
            memresp_type   <= memreq_type;
            memresp_opaque <= memreq_opaque;
            if (is_store) begin
                storage[idx] <= memreq_data;
                memresp_data <= 128'd0;
            end else begin
                memresp_data <= storage[idx];
            end
        end else if (state == WAIT) begin
            cnt <= cnt - 8'd1;
        end
    end

`ifndef SYNTHESIS
    a_resp_stable: assert property (@(posedge clk) disable iff (reset)
        (memresp_val && !memresp_rdy) |=> ($stable(memresp_type) && $stable(memresp_opaque)
                                           && $stable(memresp_data)));
    a_type_known: assert property (@(posedge clk) disable iff (reset)
        (state == IDLE && memreq_val) |-> !$isunknown(memreq_type));
`endif

endmodule

// File: tb/tb_lab3_mem_line_mem_responder.sv
// Directed bench: a latency-2 responder for the main scenarios and a latency-0 one for streaming.
module tb_lab3_mem_line_mem_responder;
    logic         clk = 1'b0;
    logic         reset = 1'b1;

    logic         req_val = 1'b0, req_rdy, resp_val, resp_rdy = 1'b0;
    logic [2:0]   req_type = 3'd0, resp_type;
    logic [7:0]   req_opaque = 8'd0, resp_opaque;
    logic [31:0]  req_addr = 32'd0;
    logic [127:0] req_data = 128'd0, resp_data;

    logic         req_val0 = 1'b0, req_rdy0, resp_val0, resp_rdy0 = 1'b1;
    logic [2:0]   req_type0 = 3'd0, resp_type0;
    logic [7:0]   req_opaque0 = 8'd0, resp_opaque0;
    logic [31:0]  req_addr0 = 32'd0;
    logic [127:0] req_data0 = 128'd0, resp_data0;

    int vecs = 0;
    int errs = 0;

    localparam logic [127:0] D_T2 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDE0F;
    localparam logic [127:0] D_T3 = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] D_IN = 128'hA5A5A5A5_0000FFFF_C3C3C3C3_01020304;

    always #5 clk = ~clk;

    lab3_mem_line_mem_responder #(.p_num_lines(16), .p_latency(2)) dut (
        .clk(clk), .reset(reset),
        .memreq_val(req_val), .memreq_rdy(req_rdy), .memreq_type(req_type),
        .memreq_opaque(req_opaque), .memreq_addr(req_addr), .memreq_data(req_data),
        .memresp_val(resp_val), .memresp_rdy(resp_rdy), .memresp_type(resp_type),
        .memresp_opaque(resp_opaque), .memresp_data(resp_data)
    );

    lab3_mem_line_mem_responder #(.p_num_lines(16), .p_latency(0)) dut0 (
        .clk(clk), .reset(reset),
        .memreq_val(req_val0), .memreq_rdy(req_rdy0), .memreq_type(req_type0),
        .memreq_opaque(req_opaque0), .memreq_addr(req_addr0), .memreq_data(req_data0),
        .memresp_val(resp_val0), .memresp_rdy(resp_rdy0), .memresp_type(resp_type0),
        .memresp_opaque(resp_opaque0), .memresp_data(resp_data0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one request from IDLE, returns fields and accept-relative latency (-1 on timeout).
    task automatic issue(input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                         input logic [127:0] d, output int lat, output logic [2:0] rt,
                         output logic [7:0] ro, output logic [127:0] rd);
        req_val = 1'b1; req_type = t; req_opaque = op; req_addr = a; req_data = d;
        step();
        req_val = 1'b0;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            if (resp_val) begin lat = i + 1; break; end
            step();
        end
        rt = resp_type; ro = resp_opaque; rd = resp_data;
        resp_rdy = 1'b1;
        step();
        resp_rdy = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        vecs++; if (req_rdy !== 1'b1) begin errs++; $display("FAIL rst_req_rdy got %b want 1", req_rdy); end
        vecs++; if (resp_val !== 1'b0) begin errs++; $display("FAIL rst_resp_val got %b want 0", resp_val); end
        vecs++; if (resp_type !== 3'd0) begin errs++; $display("FAIL rst_type got %0d want 0", resp_type); end
        vecs++; if (resp_opaque !== 8'd0) begin errs++; $display("FAIL rst_opaque got %h want 00", resp_opaque); end
        vecs++; if (resp_data !== 128'd0) begin errs++; $display("FAIL rst_data got %h want 0", resp_data); end
        vecs++; if (req_rdy0 !== 1'b1 || resp_val0 !== 1'b0) begin
            errs++; $display("FAIL rst_lat0 got rdy=%b val=%b want rdy=1 val=0", req_rdy0, resp_val0);
        end
    endtask

    task automatic test_read_zero();
        int lat; logic [2:0] rt; logic [7:0] ro; logic [127:0] rd;
        issue(3'd0, 8'hA5, 32'h0, 128'hFFFF, lat, rt, ro, rd);
        vecs++; if (lat !== 3) begin errs++; $display("FAIL t1_latency got %0d want 3", lat); end
        vecs++; if (rt !== 3'd0) begin errs++; $display("FAIL t1_type got %0d want 0", rt); end
        vecs++; if (ro !== 8'hA5) begin errs++; $display("FAIL t1_opaque got %h want a5", ro); end
        vecs++; if (rd !== 128'd0) begin errs++; $display("FAIL t1_data got %h want 0", rd); end
        vecs++; if (req_rdy !== 1'b1 || resp_val !== 1'b0) begin
            errs++; $display("FAIL t1_back_idle got rdy=%b val=%b want rdy=1 val=0", req_rdy, resp_val);
        end
    endtask

    task automatic test_write_read();
        int lat; logic [2:0] rt; logic [7:0] ro; logic [127:0] rd;
        issue(3'd1, 8'h05, 32'h1000, D_T2, lat, rt, ro, rd);
        vecs++; if (lat !== 3) begin errs++; $display("FAIL t2_wr_latency got %0d want 3", lat); end
        vecs++; if (rt !== 3'd1) begin errs++; $display("FAIL t2_wr_type got %0d want 1", rt); end
        vecs++; if (rd !== 128'd0) begin errs++; $display("FAIL t2_wr_data got %h want 0", rd); end
        issue(3'd0, 8'h05, 32'h1000, 128'd0, lat, rt, ro, rd);
        vecs++; if (rt !== 3'd0) begin errs++; $display("FAIL t2_rd_type got %0d want 0", rt); end
        vecs++; if (ro !== 8'h05) begin errs++; $display("FAIL t2_rd_opaque got %h want 05", ro); end
        vecs++; if (rd !== D_T2) begin errs++; $display("FAIL t2_rd_data got %h want %h", rd, D_T2); end
    endtask

    task automatic test_alias();
        int lat; logic [2:0] rt; logic [7:0] ro; logic [127:0] rd;
        issue(3'd1, 8'h10, 32'h000, D_T3, lat, rt, ro, rd);
        issue(3'd0, 8'h11, 32'h100, 128'd0, lat, rt, ro, rd);
        vecs++; if (rd !== D_T3) begin errs++; $display("FAIL t3_alias got %h want %h", rd, D_T3); end
        issue(3'd2, 8'h12, 32'h30, D_IN, lat, rt, ro, rd);
        vecs++; if (rt !== 3'd2 || rd !== 128'd0) begin
            errs++; $display("FAIL t3_init_resp got type=%0d data=%h want type=2 data=0", rt, rd);
        end
        issue(3'd0, 8'h13, 32'h3C, 128'd0, lat, rt, ro, rd);
        vecs++; if (rd !== D_IN) begin errs++; $display("FAIL t3_offset_ignored got %h want %h", rd, D_IN); end
        issue(3'd5, 8'h14, 32'h30, 128'hBAD, lat, rt, ro, rd);
        vecs++; if (rt !== 3'd5) begin errs++; $display("FAIL t3_illegal_type got %0d want 5", rt); end
        vecs++; if (rd !== D_IN) begin errs++; $display("FAIL t3_illegal_as_read got %h want %h", rd, D_IN); end
    endtask

    task automatic test_stall();
        int lat; logic [2:0] rt; logic [7:0] ro; logic [127:0] rd;
        bit seen;
        req_val = 1'b1; req_type = 3'd0; req_opaque = 8'h77; req_addr = 32'h30; req_data = 128'd0;
        step();
        // A write offered while busy must be ignored.
        req_type = 3'd1; req_opaque = 8'h99; req_data = 128'hBAD0BAD0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (resp_val) begin seen = 1'b1; break; end
            step();
        end
        vecs++; if (!seen) begin errs++; $display("FAIL t4_resp_timeout got no resp_val want resp_val"); end
        for (int i = 0; i < 5; i++) begin
            vecs++; if (resp_val !== 1'b1 || req_rdy !== 1'b0) begin
                errs++; $display("FAIL t4_stall_hs[%0d] got val=%b rdy=%b want val=1 rdy=0", i, resp_val, req_rdy);
            end
            vecs++; if (resp_type !== 3'd0 || resp_opaque !== 8'h77 || resp_data !== D_IN) begin
                errs++; $display("FAIL t4_stall_fields[%0d] got %0d/%h/%h want 0/77/%h", i, resp_type, resp_opaque, resp_data, D_IN);
            end
            step();
        end
        resp_rdy = 1'b1; req_val = 1'b0;
        step();
        resp_rdy = 1'b0;
        vecs++; if (req_rdy !== 1'b1 || resp_val !== 1'b0) begin
            errs++; $display("FAIL t4_idle_after got rdy=%b val=%b want rdy=1 val=0", req_rdy, resp_val);
        end
        issue(3'd0, 8'h78, 32'h30, 128'd0, lat, rt, ro, rd);
        vecs++; if (rd !== D_IN) begin errs++; $display("FAIL t4_busy_write_ignored got %h want %h", rd, D_IN); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [2:0] rt; logic [7:0] ro; logic [127:0] rd;
        bit bad;
        req_val = 1'b1; req_type = 3'd0; req_opaque = 8'h42; req_addr = 32'h30;
        step();
        req_val = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        vecs++; if (req_rdy !== 1'b1 || resp_val !== 1'b0) begin
            errs++; $display("FAIL t5_after_reset got rdy=%b val=%b want rdy=1 val=0", req_rdy, resp_val);
        end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (resp_val !== 1'b0) bad = 1'b1;
            step();
        end
        vecs++; if (bad) begin errs++; $display("FAIL t5_dropped_resp got resp_val=1 want 0"); end
        issue(3'd0, 8'h43, 32'h30, 128'd0, lat, rt, ro, rd);
        vecs++; if (rd !== 128'd0) begin errs++; $display("FAIL t5_storage_cleared got %h want 0", rd); end
        issue(3'd0, 8'h44, 32'h1000, 128'd0, lat, rt, ro, rd);
        vecs++; if (rd !== 128'd0) begin errs++; $display("FAIL t5_storage_cleared2 got %h want 0", rd); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp_d;
        logic [2:0]   exp_t;
        for (int i = 0; i < 8; i++) begin
            // Even: write line i a byte pattern; odd: read back line i-1.
            req_val0 = 1'b1;
            req_opaque0 = 8'(i);
            if (i % 2 == 0) begin
                req_type0 = 3'd1; req_addr0 = 32'(i * 16); req_data0 = {16{8'(i)}};
                exp_t = 3'd1; exp_d = 128'd0;
            end else begin
                req_type0 = 3'd0; req_addr0 = 32'((i - 1) * 16); req_data0 = 128'd0;
                exp_t = 3'd0; exp_d = {16{8'(i - 1)}};
            end
            step();
            vecs++; if (resp_val0 !== 1'b1 || req_rdy0 !== 1'b0) begin
                errs++; $display("FAIL t6_resp_cycle[%0d] got val=%b rdy=%b want val=1 rdy=0", i, resp_val0, req_rdy0);
            end
            vecs++; if (resp_opaque0 !== 8'(i) || resp_type0 !== exp_t || resp_data0 !== exp_d) begin
                errs++; $display("FAIL t6_fields[%0d] got %h/%0d/%h want %h/%0d/%h", i, resp_opaque0, resp_type0, resp_data0, 8'(i), exp_t, exp_d);
            end
            step();
            vecs++; if (resp_val0 !== 1'b0 || req_rdy0 !== 1'b1) begin
                errs++; $display("FAIL t6_idle_cycle[%0d] got val=%b rdy=%b want val=0 rdy=1", i, resp_val0, req_rdy0);
            end
        end
        req_val0 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_zero();
        test_write_read();
        test_alias();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
